// File: rtl/pipe_stall_ctrl.sv
// Hazard/sequencing controller for the F/D, D/E and E/M pipeline registers.
// Optional STALL_STATS_EN macro adds stall and redirect event counters.
module pipe_stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_D,
    input  logic [4:0] rt_D,
    input  logic       rs_use_D,
    input  logic       rt_use_D,
    input  logic [4:0] dst_E,
    input  logic       load_E,
    input  logic       md_start_E,
    input  logic       md_div_E,
    input  logic       md_use_D,
    input  logic       exc_M,
    input  logic       eret_M,
    output logic       PCEn_o,
    output logic       FDEn_o,
    output logic       Flush_FD_o,
    output logic       Flush_DE_o,
    output logic       Flush_EM_o,
    output logic [1:0] pc_sel_o,
    output logic       md_busy_o
`ifdef STALL_STATS_EN
    ,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] redirect_cnt_o
`endif
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_s;
    logic             redirect_s;
    logic             load_use_s;
    logic             md_stall_s;
    logic             stall_s;

    // MDU occupancy counter; a redirect aborts any in-flight operation
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r   <= CNT_ZERO;
            state_r <= IDLE;
        end else if (redirect_s) begin
            cnt_r   <= CNT_ZERO;
            state_r <= IDLE;
        end else if (md_start_E) begin
            cnt_r   <= md_div_E ? DIV_LD : MULT_LD;
            state_r <= MD_BUSY;
        end else if (cnt_r != CNT_ZERO) begin
            cnt_r   <= cnt_r - CNT_ONE;
            state_r <= (cnt_r == CNT_ONE) ? IDLE : MD_BUSY;
        end else begin
            cnt_r   <= cnt_r;
            state_r <= IDLE;
        end
    end

    // Hazard detection terms
    always_comb begin
        busy_s     = (state_r == MD_BUSY);
        redirect_s = exc_M | eret_M;
        load_use_s = load_E & (dst_E != 5'd0) &
                     ((rs_use_D & (rs_D == dst_E)) | (rt_use_D & (rt_D == dst_E)));
        md_stall_s = md_use_D & (busy_s | md_start_E);
        stall_s    = load_use_s | md_stall_s;
    end

    // Pipeline control: reset forcing, then redirect, then stall, then run
    always_comb begin
        PCEn_o     = 1'b1;
        FDEn_o     = 1'b1;
        Flush_FD_o = 1'b0;
        Flush_DE_o = 1'b0;
        Flush_EM_o = 1'b0;
        pc_sel_o   = 2'b00;
        md_busy_o  = 1'b0;
        if (!reset) begin
            PCEn_o     = 1'b0;
            FDEn_o     = 1'b0;
            Flush_FD_o = 1'b1;
            Flush_DE_o = 1'b1;
            Flush_EM_o = 1'b1;
        end else if (redirect_s) begin
            Flush_FD_o = 1'b1;
            Flush_DE_o = 1'b1;
            Flush_EM_o = 1'b1;
            pc_sel_o   = exc_M ? 2'b01 : 2'b10;
            md_busy_o  = busy_s;
        end else if (stall_s) begin
            PCEn_o     = 1'b0;
            FDEn_o     = 1'b0;
            Flush_DE_o = 1'b1;
            md_busy_o  = busy_s;
        end else begin
            md_busy_o  = busy_s;
        end
    end

`ifdef STALL_STATS_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] redirect_cnt_r;

    // Free-running event counters, wrap at 2^32
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_r    <= 32'd0;
            redirect_cnt_r <= 32'd0;
        end else begin
            stall_cnt_r    <= stall_cnt_r + {31'd0, stall_s};
            redirect_cnt_r <= redirect_cnt_r + {31'd0, redirect_s};
        end
    end

    assign stall_cnt_o    = stall_cnt_r;
    assign redirect_cnt_o = redirect_cnt_r;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed self-checking bench for pipe_stall_ctrl (STALL_STATS_EN optional).
module tb_pipe_stall_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs_D, rt_D, dst_E;
    logic       rs_use_D, rt_use_D, load_E, md_start_E, md_div_E, md_use_D;
    logic       exc_M, eret_M;
    logic       PCEn_o, FDEn_o, Flush_FD_o, Flush_DE_o, Flush_EM_o, md_busy_o;
    logic [1:0] pc_sel_o;
`ifdef STALL_STATS_EN
    logic [31:0] stall_cnt_o, redirect_cnt_o;
`endif

    int checks = 0;
    int failures = 0;

    // {PCEn, FDEn, Flush_FD, Flush_DE, Flush_EM, pc_sel}
    localparam logic [6:0] RUN  = 7'b11_000_00;
    localparam logic [6:0] STL  = 7'b00_010_00;
    localparam logic [6:0] EXC  = 7'b11_111_01;
    localparam logic [6:0] ERT  = 7'b11_111_10;
    localparam logic [6:0] RST  = 7'b00_111_00;

    logic [6:0] outs;
    assign outs = {PCEn_o, FDEn_o, Flush_FD_o, Flush_DE_o, Flush_EM_o, pc_sel_o};

    pipe_stall_ctrl dut (
        .clk(clk), .reset(reset), .rs_D(rs_D), .rt_D(rt_D),
        .rs_use_D(rs_use_D), .rt_use_D(rt_use_D), .dst_E(dst_E),
        .load_E(load_E), .md_start_E(md_start_E), .md_div_E(md_div_E),
        .md_use_D(md_use_D), .exc_M(exc_M), .eret_M(eret_M),
        .PCEn_o(PCEn_o), .FDEn_o(FDEn_o), .Flush_FD_o(Flush_FD_o),
        .Flush_DE_o(Flush_DE_o), .Flush_EM_o(Flush_EM_o),
        .pc_sel_o(pc_sel_o), .md_busy_o(md_busy_o)
`ifdef STALL_STATS_EN
        , .stall_cnt_o(stall_cnt_o), .redirect_cnt_o(redirect_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rs_D = 5'd0; rt_D = 5'd0; dst_E = 5'd0;
        rs_use_D = 1'b0; rt_use_D = 1'b0; load_E = 1'b0;
        md_start_E = 1'b0; md_div_E = 1'b0; md_use_D = 1'b0;
        exc_M = 1'b0; eret_M = 1'b0;
    endtask

    task automatic expect_state(input string name, input logic [6:0] exp_o, input logic exp_busy);
        @(negedge clk);
        checks++;
        if (outs !== exp_o || md_busy_o !== exp_busy) begin
            failures++;
            $display("FAIL %s: got outs=%b busy=%b, expected outs=%b busy=%b",
                     name, outs, md_busy_o, exp_o, exp_busy);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        #12;
        checks++;
        if (outs !== RST || md_busy_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_forced: got outs=%b busy=%b, expected outs=%b busy=0",
                     outs, md_busy_o, RST);
        end
        @(negedge clk);
        reset = 1'b1;
        next_cycle();
        expect_state("reset_release", RUN, 1'b0);
    endtask

    task automatic test_load_use();
        next_cycle();
        load_E = 1'b1; dst_E = 5'd8; rs_D = 5'd8; rs_use_D = 1'b1;
        expect_state("load_use_rs", STL, 1'b0);
        next_cycle();
        load_E = 1'b0;
        expect_state("load_use_cleared", RUN, 1'b0);
        next_cycle();
        load_E = 1'b1; dst_E = 5'd0; rs_D = 5'd0;
        expect_state("load_use_r0", RUN, 1'b0);
        next_cycle();
        dst_E = 5'd9; rs_D = 5'd9; rs_use_D = 1'b0; rt_D = 5'd3; rt_use_D = 1'b1;
        expect_state("load_use_rs_unused", RUN, 1'b0);
        next_cycle();
        rt_D = 5'd9;
        expect_state("load_use_rt", STL, 1'b0);
        next_cycle();
        idle_inputs();
        expect_state("load_use_idle", RUN, 1'b0);
    endtask

    task automatic test_mult();
        next_cycle();
        md_start_E = 1'b1; md_div_E = 1'b0; md_use_D = 1'b1;
        expect_state("mult_start_stall", STL, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            next_cycle();
            md_start_E = 1'b0;
            expect_state($sformatf("mult_busy_%0d", i), STL, 1'b1);
        end
        next_cycle();
        expect_state("mult_advance", RUN, 1'b0);
        next_cycle();
        idle_inputs();
        expect_state("mult_idle", RUN, 1'b0);
    endtask

    task automatic test_div_async_reset();
        next_cycle();
        md_start_E = 1'b1; md_div_E = 1'b1;
        expect_state("div_start", RUN, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            next_cycle();
            md_start_E = 1'b0;
            expect_state($sformatf("div_busy_%0d", i), RUN, 1'b1);
        end
        next_cycle();
        expect_state("div_done", RUN, 1'b0);
        // restart a divide and hit reset when the counter reads 6
        next_cycle();
        md_start_E = 1'b1; md_div_E = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            next_cycle();
            md_start_E = 1'b0;
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (outs !== RST || md_busy_o !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_mid_div: got outs=%b busy=%b, expected outs=%b busy=0",
                     outs, md_busy_o, RST);
        end
        @(negedge clk);
        #1;
        reset = 1'b1;
        next_cycle();
        expect_state("after_async_reset", RUN, 1'b0);
    endtask

    task automatic test_stats();
`ifdef STALL_STATS_EN
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            load_E = 1'b1; dst_E = 5'd4; rt_D = 5'd4; rt_use_D = 1'b1;
            next_cycle();
            idle_inputs();
        end
        next_cycle();
        eret_M = 1'b1;
        expect_state("stats_eret", ERT, 1'b0);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (stall_cnt_o !== 32'd3 || redirect_cnt_o !== 32'd1) begin
            failures++;
            $display("FAIL stats_counts: got stall=%0d redirect=%0d, expected stall=3 redirect=1",
                     stall_cnt_o, redirect_cnt_o);
        end
`endif
    endtask

    task automatic test_exception();
        next_cycle();
        md_start_E = 1'b1; md_div_E = 1'b0;
        next_cycle();
        md_start_E = 1'b0;
        expect_state("exc_setup_busy", RUN, 1'b1);
        next_cycle();
        load_E = 1'b1; dst_E = 5'd8; rs_D = 5'd8; rs_use_D = 1'b1; md_use_D = 1'b1;
        exc_M = 1'b1; eret_M = 1'b1;
        expect_state("exc_priority", EXC, 1'b1);
        next_cycle();
        idle_inputs();
        expect_state("exc_aborts_mdu", RUN, 1'b0);
        next_cycle();
        md_start_E = 1'b1; md_div_E = 1'b1; eret_M = 1'b1;
        expect_state("eret_beats_start", ERT, 1'b0);
        next_cycle();
        idle_inputs();
        expect_state("eret_no_busy", RUN, 1'b0);
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mult();
        test_div_async_reset();
        test_stats();
        test_exception();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage pipeline registers (F/D, D/E, E/M).
- Generates PC enable, F/D enable, per-stage flush/bubble and PC-source select from three inputs:
  - load-use hazard detection;
  - multiply/divide unit (MDU) busy tracking;
  - exception/eret redirects signalled from the M stage.
- Sits beside the pipeline registers; its outputs drive their enable/flush pins directly.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu issues from E.
- DIV_CYCLES, 10, busy cycles after a div/divu issues from E.
- CNT_W, 4, MDU counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- rs_D  in  5  rs index of D-stage instruction.
- rt_D  in  5  rt index of D-stage instruction.
- rs_use_D  in  1  D instruction reads rs in D/E.
- rt_use_D  in  1  D instruction reads rt in D/E.
- dst_E  in  5  destination register of E-stage instruction.
- load_E  in  1  E-stage instruction is a load.
- md_start_E  in  1  MDU op issuing from E this cycle.
- md_div_E  in  1  with md_start_E: 1 = divide, 0 = multiply.
- md_use_D  in  1  D instruction is an MDU op or reads/writes HI/LO.
- exc_M  in  1  exception taken at M stage.
- eret_M  in  1  eret at M stage.
- PCEn_o  out  1  PC register enable.
- FDEn_o  out  1  F/D register enable.
- Flush_FD_o  out  1  clear F/D register.
- Flush_DE_o  out  1  clear D/E register (bubble insert).
- Flush_EM_o  out  1  clear E/M register.
- pc_sel_o  out  2  00 sequential, 01 exception handler, 10 EPC.
- md_busy_o  out  1  MDU counter nonzero.

Behaviour:
- State: MDU counter cnt (CNT_W bits); FSM states IDLE (cnt==0) and MD_BUSY (cnt!=0).
- reset low (async): cnt=0, state IDLE. While reset is low, outputs are forced: PCEn_o=0, FDEn_o=0, all Flush_*=1, pc_sel_o=00, md_busy_o=0.
- Counter update, in priority order:
  - exc_M|eret_M -> cnt<=0, IDLE; an in-flight MDU op is aborted.
  - else md_start_E -> cnt<=md_div_E ? DIV_CYCLES : MULT_CYCLES, MD_BUSY. A restart while busy reloads the counter.
  - else cnt!=0 -> cnt<=cnt-1; IDLE when cnt becomes 0.
- md_busy_o = (cnt!=0), registered; rises the cycle after md_start_E.
- load_use = load_E & (dst_E!=0) & ((rs_use_D & rs_D==dst_E) | (rt_use_D & rt_D==dst_E)).
- md_stall = md_use_D & (md_busy_o | md_start_E).
- stall = load_use | md_stall. All outputs are combinational, 0-cycle latency.
- Output priority:
  1. redirect (exc_M|eret_M): PCEn_o=1, FDEn_o=1, Flush_FD_o=Flush_DE_o=Flush_EM_o=1. pc_sel_o=01 if exc_M, else 10; exc_M wins when both are high. Stall is ignored.
  2. stall: PCEn_o=0, FDEn_o=0, Flush_DE_o=1, Flush_FD_o=0, Flush_EM_o=0, pc_sel_o=00.
  3. otherwise: PCEn_o=1, FDEn_o=1, all flushes 0, pc_sel_o=00.
- dst_E==0 never causes a load-use stall.
- MDU stall ends in the cycle cnt reads 0; the D instruction advances that cycle.

Optional Feature:
- Macro STALL_STATS_EN.
- When defined:
  - adds outputs stall_cnt_o[31:0] and redirect_cnt_o[31:0];
  - each increments on every rising edge where stall / redirect is asserted with reset high, wrapping at 2^32;
  - both cleared by reset.
- When undefined: ports and counters absent; other behaviour identical.

Test Plan:
- Load-use: load_E=1, dst_E=8, rs_D=8, rs_use_D=1 -> PCEn_o=0, FDEn_o=0, Flush_DE_o=1 for exactly that cycle. The same with dst_E=0 -> no stall.
- MDU: md_start_E=1, md_div_E=0, then md_use_D=1 held -> stall asserted for the start cycle plus 5 busy cycles. md_busy_o high for 5 cycles; the D instruction advances on cycle 6.
- Divide: md_start_E=1, md_div_E=1 -> md_busy_o high for 10 cycles, cnt decrements 10..1.
- Exception priority: during MD_BUSY with load_use active, pulse exc_M=1 and eret_M=1 -> pc_sel_o=01, all three flushes=1, PCEn_o=1. Next cycle md_busy_o=0.
- Async reset: assert reset low mid-divide (cnt=6) between clock edges -> outputs immediately PCEn_o=0, flushes=1. After release, cnt=0 and outputs are 1/1/0/0/0/00.
- STALL_STATS_EN: 3 load-use stalls, then 1 eret -> stall_cnt_o=3, redirect_cnt_o=1.
